// File: rtl/mux4_word_select_pkg.sv
// rtl/mux4_word_select_pkg.sv - select-field constants and word-index encoding for the 4:1 word selector
//
// Purpose : shared select-field width and the symbolic word index used by the
//           selector's decode and its port bundle.
// Contents: SEL_W       - width of the word select field
//           NUM_WORDS   - number of candidate words (always 2**SEL_W)
//           word_sel_e  - symbolic word index, one literal per candidate word

package mux4_word_select_pkg;

    localparam int SEL_W     = 2;
    localparam int NUM_WORDS = 1 << SEL_W;

    // Word index as sliced from a cache address's word-offset bits [3:2].
    typedef enum logic [SEL_W-1:0] {
        WORD_0 = 2'd0,
        WORD_1 = 2'd1,
        WORD_2 = 2'd2,
        WORD_3 = 2'd3
    } word_sel_e;

endpackage

// File: rtl/mux4_word_select_if.sv
// rtl/mux4_word_select_if.sv - signal bundle between a word selector and the logic that drives it
//
// Purpose : groups the select, candidate words, capture enable and both output
//           paths of mux4_word_select. Clock and reset are not part of the bundle.
// Signals : sel_i         word select (0..3)
//           in0_i..in3_i  candidate words, WIDTH bits each
//           en_i          capture enable for the registered path
//           out_o         combinational selected word
//           out_q_o       registered selected word
//           valid_q_o     one-cycle strobe per capture
// Modports: master - drives select/words/enable, observes outputs
//           slave  - the selector itself

interface mux4_word_select_if
    import mux4_word_select_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic [SEL_W-1:0] sel_i;
    logic [WIDTH-1:0] in0_i;
    logic [WIDTH-1:0] in1_i;
    logic [WIDTH-1:0] in2_i;
    logic [WIDTH-1:0] in3_i;
    logic             en_i;
    logic [WIDTH-1:0] out_o;
    logic [WIDTH-1:0] out_q_o;
    logic             valid_q_o;

    modport master (
        output sel_i,
        output in0_i,
        output in1_i,
        output in2_i,
        output in3_i,
        output en_i,
        input  out_o,
        input  out_q_o,
        input  valid_q_o
    );

    modport slave (
        input  sel_i,
        input  in0_i,
        input  in1_i,
        input  in2_i,
        input  in3_i,
        input  en_i,
        output out_o,
        output out_q_o,
        output valid_q_o
    );

endinterface

// File: rtl/mux4_word_select.sv
// rtl/mux4_word_select.sv - 4:1 word selector with combinational output and optional registered copy
//
// Purpose : picks one WIDTH-bit word out of four by a 2-bit select. The
//           combinational path serves same-cycle cache reads; the optional
//           registered path serves pipelined consumers.
// Params  : WIDTH   - bits per word and per output (>= 1)
//           REG_OUT - 1: registered path present; 0: out_q_o/valid_q_o tied low, no flops
// Ports   : clk_i   - clock, rising edge
//           rst_ni  - asynchronous active-low reset (release synchronised by the parent)
//           bus     - mux4_word_select_if.slave: sel_i, in0_i..in3_i, en_i in;
//                     out_o, out_q_o, valid_q_o out

module mux4_word_select
    import mux4_word_select_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mux4_word_select_if.slave   bus
);

    logic [WIDTH-1:0] sel_word;

    // Every select value names exactly one word. The leading X assignment
    // never wins for a known select; it only lets an X/Z select show up as
    // an X word in simulation instead of silently aliasing to some input.
    always_comb begin
        sel_word = 'x;
        case (bus.sel_i)
            WORD_0: sel_word = bus.in0_i;
            WORD_1: sel_word = bus.in1_i;
            WORD_2: sel_word = bus.in2_i;
            WORD_3: sel_word = bus.in3_i;
        endcase
    end

    assign bus.out_o = sel_word;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] word_q;
            logic             valid_q;

            // valid_q follows en_i so it strobes once per capture and stays
            // high across back-to-back captures; word_q holds when idle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    word_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= bus.en_i;
                    if (bus.en_i) begin
                        word_q <= sel_word;
                    end
                end
            end

            assign bus.out_q_o   = word_q;
            assign bus.valid_q_o = valid_q;
        end else begin : g_no_reg
            assign bus.out_q_o   = '0;
            assign bus.valid_q_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mux4_word_select.sv
// tb/tb_mux4_word_select.sv - scoreboard bench for mux4_word_select (registered and unregistered builds)

module tb_mux4_word_select;

    typedef struct {
        bit          v;
        logic [31:0] q;
    } exp_t;

    logic clk_i;
    logic rst_ni;

    int tests = 0;
    int fails = 0;

    exp_t        sb[$];
    logic [31:0] model_q;

    mux4_word_select_if #(.WIDTH(32)) bus ();
    mux4_word_select_if #(.WIDTH(8))  sm  ();

    mux4_word_select #(.WIDTH(32), .REG_OUT(1'b1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    mux4_word_select #(.WIDTH(8), .REG_OUT(1'b0)) dut_sm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (sm.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising edge the registered outputs are compared with the
    // oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid_q", {31'd0, bus.valid_q_o}, {31'd0, e.v});
                chk("out_q",   bus.out_q_o, e.q);
            end
        end
    end

    // One cycle of stimulus: apply on the falling edge, check the
    // combinational word, and queue what the next rising edge must produce.
    task automatic drive(input bit en, input logic [1:0] s,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] words [4];
        exp_t e;
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        @(negedge clk_i);
        bus.sel_i = s;
        bus.in0_i = w0; bus.in1_i = w1; bus.in2_i = w2; bus.in3_i = w3;
        bus.en_i  = en;
        #1;
        chk("out_o", bus.out_o, words[s]);
        if (en) model_q = words[s];
        e.v = en;
        e.q = model_q;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk_i);
            #2;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic sweep_comb();
        logic [31:0] words [4];
        words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
        bus.in0_i = words[0]; bus.in1_i = words[1];
        bus.in2_i = words[2]; bus.in3_i = words[3];
        for (int s = 0; s < 4; s++) begin
            bus.sel_i = 2'(s);
            #1;
            chk("sweep_out_o", bus.out_o, words[s]);
        end
    endtask

    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;
    localparam logic [31:0] W2 = 32'h3333_3333;
    localparam logic [31:0] W3 = 32'h4444_4444;

    initial begin
        logic [127:0] block;
        logic [31:0]  addr;
        logic [1:0]   s;
        logic [7:0]   b [4];

        rst_ni    = 1'b0;
        bus.en_i  = 1'b0;
        bus.sel_i = 2'd0;
        sm.en_i   = 1'b0;
        sm.sel_i  = 2'd0;
        sm.in0_i  = 8'h00; sm.in1_i = 8'h00; sm.in2_i = 8'h00; sm.in3_i = 8'h00;
        model_q   = 32'd0;

        #1;
        chk("rst_out_q",   bus.out_q_o, 32'd0);
        chk("rst_valid_q", {31'd0, bus.valid_q_o}, 32'd0);
        sweep_comb();

        // Cache-style: word offset is address bits [3:2].
        block     = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        addr      = 32'h0000_0048;
        s         = 2'((addr >> 2) % 4);
        bus.in0_i = block[31:0];   bus.in1_i = block[63:32];
        bus.in2_i = block[95:64];  bus.in3_i = block[127:96];
        bus.sel_i = s;
        #1;
        chk("cache_out_o", bus.out_o, 32'hCCCC_CCCC);

        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single capture, then idle with a different select.
        drive(1'b1, 2'd2, W0, W1, W2, W3);
        drive(1'b0, 2'd0, W0, W1, W2, W3);
        drive(1'b0, 2'd1, W0, W1, W2, W3);
        // Back-to-back captures.
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), W0, W1, W2, W3);
        drive(1'b0, 2'd3, W0, W1, W2, W3);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, $urandom);
        end
        drain();

        // Mid-stream reset with 0x33333333 held in the register.
        drive(1'b1, 2'd2, W0, W1, W2, W3);
        drive(1'b0, 2'd0, W0, W1, W2, W3);
        drain();
        chk("pre_rst_out_q", bus.out_q_o, W2);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_out_q",   bus.out_q_o, 32'd0);
        chk("async_rst_valid_q", {31'd0, bus.valid_q_o}, 32'd0);
        sweep_comb();
        @(posedge clk_i);
        #1;
        chk("held_rst_out_q", bus.out_q_o, 32'd0);
        model_q = 32'd0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b0, 2'd3, W0, W1, W2, W3);
        drive(1'b1, 2'd3, W0, W1, W2, W3);
        drive(1'b1, 2'd1, W0, W1, W2, W3);
        drive(1'b0, 2'd2, W0, W1, W2, W3);
        drain();

        // Unregistered 8-bit build.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            if (i == 0) begin
                s = 2'd3;
                b[3] = 8'hA5;
            end else begin
                s = 2'($urandom_range(0, 3));
            end
            sm.sel_i = s;
            sm.in0_i = b[0]; sm.in1_i = b[1]; sm.in2_i = b[2]; sm.in3_i = b[3];
            sm.en_i  = 1'($urandom_range(0, 1));
            #1;
            chk("sm_out_o", {24'd0, sm.out_o}, {24'd0, b[s]});
            @(posedge clk_i);
            #1;
            chk("sm_out_q",   {24'd0, sm.out_q_o}, 32'd0);
            chk("sm_valid_q", {31'd0, sm.valid_q_o}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
